// File: rtl/capture_pkg.sv
// Shared definitions for the logic-capture blocks: default widths and the readout FSM encoding.
// CAPTURE_READOUT_CHECKSUM_EN adds the CHK state used to send the trailing XOR byte.
package capture_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;

    // Explicit values keep the encoding identical whether or not CHK is built in
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
`ifdef CAPTURE_READOUT_CHECKSUM_EN
        ST_CHK  = 3'd4,
`endif
        ST_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/capture_readout.sv
// Streams a finished capture out of sample RAM, oldest sample first, over a valid/ready byte port.
// Define CAPTURE_READOUT_CHECKSUM_EN to append a running-XOR checksum byte after the last sample.
module capture_readout
    import capture_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

`ifdef CAPTURE_READOUT_CHECKSUM_EN
    localparam state_t ST_LAST = ST_CHK;
`else
    localparam state_t ST_LAST = ST_DONE;
`endif

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [ADDR_W:0]     rem_reg, rem_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic [ADDR_W:0]     count_clamp;

`ifdef CAPTURE_READOUT_CHECKSUM_EN
    logic [DATA_W-1:0]   xor_reg, xor_next;
`endif

    // A count larger than the buffer would re-send samples, so clamp to one full lap
    assign count_clamp = (count > DEPTH) ? DEPTH : count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            rem_reg   <= '0;
            data_reg  <= '0;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
            xor_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            rem_reg   <= rem_next;
            data_reg  <= data_next;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
            xor_reg   <= xor_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        rem_next   = rem_reg;
        data_next  = data_reg;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
        xor_next   = xor_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (start && !abort) begin
                    addr_next  = base_addr;
                    rem_next   = count_clamp;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
                    xor_next   = '0;
`endif
                    state_next = (count_clamp == '0) ? ST_LAST : ST_READ;
                end
            end
            ST_READ: state_next = ST_WAIT;
            ST_WAIT: begin
                data_next  = ram_dout;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    addr_next  = addr_reg + 1'b1;
                    rem_next   = rem_reg - ONE;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
                    xor_next   = xor_reg ^ data_reg;
`endif
                    state_next = (rem_reg == ONE) ? ST_LAST : ST_READ;
                end
            end
`ifdef CAPTURE_READOUT_CHECKSUM_EN
            ST_CHK: begin
                if (tx_ready) state_next = ST_DONE;
            end
`endif
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        // Abort overrides everything, including a pending handshake
        if (abort && (state_reg != ST_IDLE)) state_next = ST_IDLE;
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        ram_en   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = data_reg;
        ram_addr = addr_reg;
        case (state_reg)
            ST_READ: begin
                busy   = 1'b1;
                ram_en = 1'b1;
            end
            ST_WAIT: busy = 1'b1;
            ST_SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
            end
`ifdef CAPTURE_READOUT_CHECKSUM_EN
            ST_CHK: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = xor_reg;
            end
`endif
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_capture_readout.sv
// Scoreboard bench for capture_readout (ADDR_W=4); expected bytes are queued at start and popped on handshake.
module tb_capture_readout;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset, start, abort, tx_ready;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          busy, done, ram_en, tx_valid;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout, tx_data;

    logic [7:0]    mem [16];
    logic [7:0]    exp_q [$];
    logic [AW-1:0] addr_log [$];
    logic [7:0]    exp_byte;
    int            vectors = 0;
    int            miscompares = 0;
    int            ram_en_cnt = 0;
    int            done_cnt = 0;

    capture_readout #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .count(count), .busy(busy), .done(done),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) ram_dout <= mem[ram_addr];
    end

    // Stream monitor: every handshake is checked against the head of the scoreboard
    always @(negedge clk) begin
        if (ram_en) begin
            addr_log.push_back(ram_addr);
            ram_en_cnt++;
        end
        if (done) done_cnt++;
        if (tx_valid && tx_ready && !reset) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL byte: tx_data=%h sent, none required", tx_data);
            end else begin
                exp_byte = exp_q.pop_front();
                if (tx_data !== exp_byte) begin
                    miscompares++;
                    $display("FAIL byte: tx_data=%h required %h", tx_data, exp_byte);
                end else begin
                    $display("byte %h", tx_data);
                end
            end
        end
    end

    function automatic int exp_cycles(input int n);
`ifdef CAPTURE_READOUT_CHECKSUM_EN
        return 3 * n + 2;
`else
        return 3 * n + 1;
`endif
    endfunction

    task automatic push_stream(input int b, input int n);
        logic [7:0] x;
        logic [7:0] v;
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            v = 8'((b + i) % 16) ^ 8'hA5;
            exp_q.push_back(v);
            x = x ^ v;
        end
`ifdef CAPTURE_READOUT_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic do_start(input int b, input int n);
        @(posedge clk); #1;
        base_addr = AW'(b);
        count     = (AW + 1)'(n);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: done=0 after 300 cycles, required 1");
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (tx_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (tx_valid !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL valid_timeout: tx_valid=%b, required 1", tx_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
        base_addr = '0; count = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, ram_en, tx_valid, ram_addr, tx_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b done=%b ram_en=%b tx_valid=%b ram_addr=%h tx_data=%h, required all 0",
                     busy, done, ram_en, tx_valid, ram_addr, tx_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        addr_log.delete();
        tx_ready = 1'b1;
        push_stream(0, 4);
        do_start(0, 4);
        vectors++;
        if (ram_en !== 1'b1 || ram_addr !== 4'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_first_read: ram_en=%b ram_addr=%0d busy=%b, required 1 0 1", ram_en, ram_addr, busy);
        end
        @(posedge clk); #1;
        vectors++;
        if (tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_early_valid: tx_valid=%b at start+2, required 0", tx_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if (tx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_first_valid: tx_valid=%b at start+3, required 1", tx_valid);
        end
        wait_done(cyc);
        vectors++;
        if (cyc + 2 != exp_cycles(4) || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done: done at cycle %0d busy=%b, required cycle %0d busy 0", cyc + 2, busy, exp_cycles(4));
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL basic_end: done=%b pending=%0d, required 0 0", done, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        int cyc;
        int exp_a[4] = '{14, 15, 0, 1};
        addr_log.delete();
        tx_ready = 1'b1;
        push_stream(14, 4);
        do_start(14, 4);
        wait_done(cyc);
        vectors++;
        if (cyc != exp_cycles(4) || addr_log.size() != 4) begin
            miscompares++;
            $display("FAIL wrap_timing: done cycle %0d reads %0d, required %0d reads 4", cyc, addr_log.size(), exp_cycles(4));
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (addr_log[i] !== AW'(exp_a[i])) begin
                    miscompares++;
                    $display("FAIL wrap_addr%0d: ram_addr=%0d required %0d", i, addr_log[i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int cyc;
        int nb;
        logic [7:0] held;
        addr_log.delete();
        ram_en_cnt = 0;
        tx_ready = 1'b0;
        push_stream(0, 4);
        nb = exp_q.size();
        do_start(0, 4);
        for (int bi = 0; bi < nb; bi++) begin
            wait_valid();
            if (bi == 1) begin
                held = tx_data;
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); #1;
                    vectors++;
                    if (tx_valid !== 1'b1 || tx_data !== held || ram_en !== 1'b0) begin
                        miscompares++;
                        $display("FAIL stall_hold%0d: tx_valid=%b tx_data=%h ram_en=%b, required 1 %h 0",
                                 s, tx_valid, tx_data, ram_en, held);
                    end
                end
            end
            tx_ready = 1'b1;
            @(posedge clk); #1;
            tx_ready = 1'b0;
        end
        wait_done(cyc);
        vectors++;
        if (ram_en_cnt != 4 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stall_reads: ram_en pulses=%0d pending=%0d, required 4 0", ram_en_cnt, exp_q.size());
        end
    endtask

    task automatic test_count0();
        int cyc;
        tx_ready = 1'b1;
        ram_en_cnt = 0;
        push_stream(0, 0);
        do_start(0, 0);
        wait_done(cyc);
        vectors++;
        if (cyc != exp_cycles(0) || ram_en_cnt != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL count0: done cycle %0d reads %0d pending %0d, required %0d 0 0",
                     cyc, ram_en_cnt, exp_q.size(), exp_cycles(0));
        end
    endtask

    task automatic test_abort();
        int cyc;
        int dsnap;
        tx_ready = 1'b0;
        exp_q.push_back(8'hA5);
        do_start(0, 8);
        wait_valid();
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        wait_valid();
        dsnap = done_cnt;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        vectors++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: tx_valid=%b busy=%b, required 0 0", tx_valid, busy);
        end
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (done_cnt != dsnap || exp_q.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_quiet: done pulses=%0d pending=%0d busy=%b, required %0d 0 0",
                     done_cnt - dsnap, exp_q.size(), busy, 0);
        end
        // abort and start together while idle: nothing may begin
        base_addr = 4'd5; count = 5'd2; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        vectors++;
        if (busy !== 1'b0 || ram_en !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_vs_start: busy=%b ram_en=%b, required 0 0", busy, ram_en);
        end
        tx_ready = 1'b1;
        push_stream(3, 1);
        do_start(3, 1);
        wait_done(cyc);
        vectors++;
        if (cyc != exp_cycles(1) || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL abort_restart: done cycle %0d pending %0d, required %0d 0", cyc, exp_q.size(), exp_cycles(1));
        end
    endtask

    task automatic test_checksum();
        int cyc;
        tx_ready = 1'b1;
        push_stream(0, 3);
        do_start(0, 3);
        wait_done(cyc);
        vectors++;
        if (cyc != exp_cycles(3) || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL checksum: done cycle %0d pending %0d, required %0d 0", cyc, exp_q.size(), exp_cycles(3));
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        tx_ready = 1'b1;
        push_stream(0, 8);
        do_start(0, 8);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({busy, done, ram_en, tx_valid, ram_addr, tx_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b done=%b ram_en=%b tx_valid=%b ram_addr=%h tx_data=%h, required all 0",
                     busy, done, ram_en, tx_valid, ram_addr, tx_data);
        end
        reset = 1'b0;
        exp_q.delete();
        addr_log.delete();
        push_stream(0, 2);
        do_start(0, 2);
        base_addr = 4'd9; count = 5'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc);
        vectors++;
        if (cyc + 1 != exp_cycles(2) || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL busy_start: done cycle %0d pending %0d, required %0d 0", cyc + 1, exp_q.size(), exp_cycles(2));
        end
        vectors++;
        if (addr_log.size() != 2 || addr_log[0] !== 4'd0 || addr_log[1] !== 4'd1) begin
            miscompares++;
            $display("FAIL busy_start_addr: %0d reads first=%0d, required 2 reads 0,1", addr_log.size(), addr_log[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(i) ^ 8'hA5;
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_count0();
        test_abort();
        test_checksum();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
